cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, pipelined carry-look-ahead adder/subtractor and the successor to the fixed 16-bit, four-group combinational CLA. Operand width, CLA group width and the number of groups resolved per pipeline stage are parameters. An add/subtract mode bit, signed-overflow detection and a valid/ready handshake with full back-pressure are added. The block sits in the datapath as a drop-in arithmetic unit for wide (32/64-bit) operands that must close timing at full clock rate.

## Interface
- WIDTH, 32, operand and result width in bits; must be a multiple of GROUP*GPS.
- GROUP, 4, bits per CLA group (generate/propagate look-ahead within a group).
- GPS, 2, CLA groups resolved per pipeline stage; carry ripples group-to-group inside a stage.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add mode only).
- sub  input  1  0: a+b+cin; 1: a-b (computed as a+~b+1; cin ignored).
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of MSB (in sub mode: 1 means no borrow).
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Derived constants: SLICE = GROUP*GPS bits per stage; L = WIDTH/SLICE stages = latency.
- Elaboration fails if WIDTH % SLICE != 0, or if GROUP, GPS or WIDTH is 0.
- Stage k (0..L-1) adds bits [k*SLICE +: SLICE] using the carry registered from stage k-1. Stage 0 uses cin, or 1 when sub=1.
- The effective B is (sub ? ~b : b), formed at input before stage 0 and registered with the operands.
- Operand skew: upper slices not yet consumed are carried forward in stage registers. Result de-skew: lower sum slices already produced are carried forward, so that sum, cout and ovf of one beat emerge together.
- ovf is computed in the final stage from the carry into bit WIDTH-1 and cout.
- Pipeline control is a global stall. The advance signal is adv = !out_valid || out_ready, and in_ready = adv.
- When adv=1, every stage register loads from its predecessor, and each stage valid bit shifts. Stage-0 valid loads in_valid.
- When adv=0, all stage registers and valid bits hold. The output beat holds stable.
- Bubbles (valid=0) propagate like data; their data content is don't-care but must not toggle outputs while out_valid=0. Sum, cout and ovf hold their last value.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by system):
  - all stage valid bits = 0, out_valid = 0;
  - sum = 0, cout = 0, ovf = 0;
  - in_ready = 1 combinationally once out_valid = 0.
- Latency: a beat accepted on edge n (in_valid && in_ready) presents out_valid=1 with its result after edge n+L, with no stall. L=4 for the defaults.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 holds the entire pipe. in_ready=0 the same cycle (combinational from out_ready). There is no beat loss or duplication.
- Simultaneous accept and drain: out_valid=1 && out_ready=1 && in_valid=1 completes both transfers on the same edge.
- Reset mid-operation: all in-flight beats are discarded and none appear after rst_n deasserts.
- Critical path per stage: GPS group look-ahead units in ripple plus one carry register. There are no combinational paths from a/b to sum.

## Test plan
- Defaults, out_ready=1, single beat a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 4 cycles out_valid=1 for exactly one cycle, sum=0x00000000, cout=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 add -> sum=0x80000000, cout=0, ovf=1. Then a=0x80000000, b=0x00000001, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Back-to-back stream of 100 random beats with random sub/cin, out_ready=1 -> 100 results in order, each matching the reference model, with one result per cycle after the initial 4-cycle latency.
- Back-pressure: out_ready toggled randomly 50% over 200 beats -> in_ready==out_ready||!out_valid every cycle, sum/cout/ovf stable while stalled, no lost or duplicated beats.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0 and sum=0 immediately; after release no stale beat emerges; next beat a=5, b=3 returns sum=8 at latency 4.
- Parameter sweep: (WIDTH,GROUP,GPS) = (16,4,4) L=1, (64,4,2) L=8, (8,2,1) L=4 -> random add/sub passes the model, with latency equal to L in each case.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-look-ahead adder/subtractor: SLICE = GROUP*GPS bits resolved per
// stage, L = WIDTH/SLICE stages behind an operand register, global-stall back-pressure.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4,
  parameter int GPS   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = GROUP * GPS;
  localparam int SDIV  = (SLICE <= 0) ? 1 : SLICE;
  localparam int L     = (WIDTH / SDIV < 1) ? 1 : WIDTH / SDIV;
  localparam bit BAD   = (GROUP <= 0) || (GPS <= 0) || (WIDTH <= 0) || ((WIDTH % SDIV) != 0);

  generate
    if (BAD) begin : g_bad_params
      $error("cla_pipe_adder: WIDTH must be a nonzero multiple of GROUP*GPS");
    end
  endgenerate

  // Handshake: a beat moves on every edge where adv is high; adv = !out_valid || out_ready
  // stalls the whole pipe, so in_ready = adv and a beat is accepted when in_valid && in_ready.
  logic                 adv;
  logic                 v_q    [0:L];
  logic [WIDTH-1:0]     acc_q  [0:L];
  logic                 c_q    [0:L];
  logic [WIDTH-1:0]     b_q    [0:L-1];
  logic                 ovf_q;
  logic [SLICE+1:0]     st_res [0:L-1];
  logic [WIDTH-1:0]     st_acc [0:L-1];

  // Returns {carry out, carry into slice MSB, slice sum}. Carries look ahead from the
  // group carry-in inside a group and ripple from group to group.
  function automatic logic [SLICE+1:0] slice_add(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y,
                                                 input logic ci);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   cy;
    logic             lc;
    logic             term;
    g     = x & y;
    p     = x ^ y;
    cy    = '0;
    cy[0] = ci;
    for (int grp = 0; grp < GPS; grp++) begin
      for (int i = 0; i < GROUP; i++) begin
        lc = cy[grp*GROUP];
        for (int m = 0; m <= i; m++) lc = lc & p[grp*GROUP+m];
        for (int j = 0; j <= i; j++) begin
          term = g[grp*GROUP+j];
          for (int m = j + 1; m <= i; m++) term = term & p[grp*GROUP+m];
          lc = lc | term;
        end
        cy[grp*GROUP+i+1] = lc;
      end
    end
    return {cy[SLICE], cy[SLICE-1], p ^ cy[SLICE-1:0]};
  endfunction

  // acc_q[k] holds finished sum slices below slice k and untouched A bits above it.
  always_comb begin
    for (int k = 0; k < L; k++) begin
      st_res[k] = slice_add(acc_q[k][k*SLICE +: SLICE], b_q[k][k*SLICE +: SLICE], c_q[k]);
      st_acc[k] = acc_q[k];
      st_acc[k][k*SLICE +: SLICE] = st_res[k][SLICE-1:0];
    end
  end

  assign adv       = !v_q[L] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[L];
  assign sum       = acc_q[L];
  assign cout      = c_q[L];
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= L; k++) begin
        v_q[k]   <= 1'b0;
        acc_q[k] <= '0;
        c_q[k]   <= 1'b0;
      end
      for (int k = 0; k < L; k++) b_q[k] <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      v_q[0]   <= in_valid;
      acc_q[0] <= a;
      b_q[0]   <= sub ? ~b : b;
      c_q[0]   <= sub | cin;
      for (int k = 1; k < L; k++) b_q[k] <= b_q[k-1];
      for (int k = 0; k < L - 1; k++) begin
        acc_q[k+1] <= st_acc[k];
        c_q[k+1]   <= st_res[k][SLICE+1];
      end
      for (int k = 0; k < L; k++) v_q[k+1] <= v_q[k];
      // Output registers only take real beats so bubbles never disturb sum/cout/ovf.
      if (v_q[L-1]) begin
        acc_q[L] <= st_acc[L-1];
        c_q[L]   <= st_res[L-1][SLICE+1];
        ovf_q    <= st_res[L-1][SLICE+1] ^ st_res[L-1][SLICE];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: default instance gets directed, streaming, back-pressure and
// reset tests; three more instances cover other WIDTH/GROUP/GPS shapes.
module tb_cla_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  logic        in_valid_s, cin_s, sub_s;
  logic [63:0] a_s, b_s;
  logic        ir16, ov16, co16, of16;
  logic        ir64, ov64, co64, of64;
  logic        ir8, ov8, co8, of8;
  logic [15:0] sum16;
  logic [63:0] sum64;
  logic [7:0]  sum8;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ov_count = 0;
  bit bp       = 0;
  bit chk_lat  = 1;

  // entry = {accept cycle[31:0], ovf, cout, sum[63:0]}
  logic [97:0] exp_q0[$];
  logic [97:0] exp_q16[$];
  logic [97:0] exp_q64[$];
  logic [97:0] exp_q8[$];

  logic        stall_prev = 0;
  logic [31:0] prev_sum;
  logic        prev_cout, prev_ovf;

  cla_pipe_adder u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf));

  cla_pipe_adder #(.WIDTH(16), .GROUP(4), .GPS(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(ir16), .a(a_s[15:0]),
    .b(b_s[15:0]), .cin(cin_s), .sub(sub_s), .out_valid(ov16), .out_ready(1'b1),
    .sum(sum16), .cout(co16), .ovf(of16));

  cla_pipe_adder #(.WIDTH(64), .GROUP(4), .GPS(2)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(ir64), .a(a_s),
    .b(b_s), .cin(cin_s), .sub(sub_s), .out_valid(ov64), .out_ready(1'b1),
    .sum(sum64), .cout(co64), .ovf(of64));

  cla_pipe_adder #(.WIDTH(8), .GROUP(2), .GPS(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(ir8), .a(a_s[7:0]),
    .b(b_s[7:0]), .cin(cin_s), .sub(sub_s), .out_valid(ov8), .out_ready(1'b1),
    .sum(sum8), .cout(co8), .ovf(of8));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: two's-complement add of a and effective b; overflow from operand/result signs.
  function automatic logic [97:0] mk_exp(input int w, input logic [63:0] x, input logic [63:0] y,
                                         input logic ci, input logic sb, input int cy);
    logic [64:0] mask, be, full;
    logic [63:0] s;
    logic        co, ov;
    mask = (65'd1 << w) - 65'd1;
    be   = {1'b0, (sb ? ~y : y)} & mask;
    full = ({1'b0, x} & mask) + be + 65'(sb | ci);
    co   = full[w];
    s    = full[63:0] & mask[63:0];
    ov   = (x[w-1] == be[w-1]) && (s[w-1] != x[w-1]);
    return {32'(cy), ov, co, s};
  endfunction

  task automatic check_beat(input string tag, input logic [63:0] s, input logic co,
                            input logic of, input logic [97:0] e, input int lat, input bit do_lat);
    check({tag, "_sum"}, s, e[63:0]);
    check({tag, "_cout"}, 64'(co), 64'(e[64]));
    check({tag, "_ovf"}, 64'(of), 64'(e[65]));
    if (do_lat) check({tag, "_latency"}, 64'(cyc - int'(e[97:66])), 64'(lat));
  endtask

  // driver tasks
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic tcin, input logic tsub);
    int tries;
    bit done;
    tries = 0;
    done  = 0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1; a = ta; b = tb_; cin = tcin; sub = tsub;
      if (bp) out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_ready) begin
        exp_q0.push_back(mk_exp(32, {32'd0, ta}, {32'd0, tb_}, tcin, tsub, cyc + 1));
        done = 1;
      end else if (++tries > 100) begin
        check("send_accept", 64'(in_ready), 64'd1);
        done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid   = 1'b0;
      in_valid_s = 1'b0;
      if (bp) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic sweep_send(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic sb);
    @(negedge clk);
    in_valid = 1'b0;
    in_valid_s = 1'b1; a_s = x; b_s = y; cin_s = ci; sub_s = sb;
    #1;
    check("u16_in_ready", 64'(ir16), 64'd1);
    check("u64_in_ready", 64'(ir64), 64'd1);
    check("u8_in_ready", 64'(ir8), 64'd1);
    exp_q16.push_back(mk_exp(16, x, y, ci, sb, cyc + 1));
    exp_q64.push_back(mk_exp(64, x, y, ci, sb, cyc + 1));
    exp_q8.push_back(mk_exp(8, x, y, ci, sb, cyc + 1));
  endtask

  // scoreboard / monitors
  always @(negedge clk) begin : mon_main
    logic [97:0] e;
    #2;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", 64'(in_ready), 64'(out_ready || !out_valid));
      if (stall_prev) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_sum", {32'd0, sum}, {32'd0, prev_sum});
        check("stall_cout", 64'(cout), 64'(prev_cout));
        check("stall_ovf", 64'(ovf), 64'(prev_ovf));
      end
      if (out_valid) ov_count++;
      if (out_valid && out_ready) begin
        if (exp_q0.size() == 0) check("main_beat_expected", 64'(exp_q0.size()), 64'd1);
        else begin
          e = exp_q0.pop_front();
          check_beat("main", {32'd0, sum}, cout, ovf, e, 4, chk_lat);
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_sum   = sum;
      prev_cout  = cout;
      prev_ovf   = ovf;
    end
  end

  always @(negedge clk) begin : mon16
    logic [97:0] e;
    #2;
    if (rst_n && ov16) begin
      if (exp_q16.size() == 0) check("u16_beat_expected", 64'(exp_q16.size()), 64'd1);
      else begin
        e = exp_q16.pop_front();
        check_beat("u16", {48'd0, sum16}, co16, of16, e, 1, 1'b1);
      end
    end
  end

  always @(negedge clk) begin : mon64
    logic [97:0] e;
    #2;
    if (rst_n && ov64) begin
      if (exp_q64.size() == 0) check("u64_beat_expected", 64'(exp_q64.size()), 64'd1);
      else begin
        e = exp_q64.pop_front();
        check_beat("u64", sum64, co64, of64, e, 8, 1'b1);
      end
    end
  end

  always @(negedge clk) begin : mon8
    logic [97:0] e;
    #2;
    if (rst_n && ov8) begin
      if (exp_q8.size() == 0) check("u8_beat_expected", 64'(exp_q8.size()), 64'd1);
      else begin
        e = exp_q8.pop_front();
        check_beat("u8", {56'd0, sum8}, co8, of8, e, 4, 1'b1);
      end
    end
  end

  // directed sequence
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid_s = 1'b0; a_s = '0; b_s = '0; cin_s = 1'b0; sub_s = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", {32'd0, sum}, 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_u64_valid", 64'(ov64), 64'd0);
    rst_n = 1'b1;

    // carry through all bits, single beat visible for one cycle
    ov_count = 0;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    idle(7);
    check("single_beat_cycles", 64'(ov_count), 64'd1);

    // signed overflow in add and subtract
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    send(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    idle(6);

    // back-to-back random stream
    for (int i = 0; i < 100; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(6);

    // random back-pressure
    chk_lat = 1'b0;
    bp = 1'b1;
    for (int i = 0; i < 200; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    bp = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q0.size() > 0; i++) idle(1);
    check("bp_drained", 64'(exp_q0.size()), 64'd0);
    idle(2);
    chk_lat = 1'b1;

    // reset with three beats in flight
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    send(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0);
    send(32'hDEAD_BEEF, 32'h0000_BEEF, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", {32'd0, sum}, 64'd0);
    exp_q0.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ov_count = 0;
    idle(8);
    check("midrst_no_stale", 64'(ov_count), 64'd0);
    send(32'd5, 32'd3, 1'b0, 1'b0);
    idle(6);

    // parameter sweep instances
    sweep_send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    sweep_send(64'h7FFF_FFFF_FFFF_7F7F, 64'd1, 1'b0, 1'b0);
    sweep_send(64'h8000_0000_0000_8080, 64'd1, 1'b0, 1'b1);
    sweep_send(64'd0, 64'd0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++)
      sweep_send({$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(1);
    for (int i = 0; i < 5; i++)
      sweep_send({$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(1);

    for (int i = 0; i < 50 && (exp_q0.size() + exp_q16.size() + exp_q64.size() + exp_q8.size()) > 0; i++)
      idle(1);
    check("final_drain_main", 64'(exp_q0.size()), 64'd0);
    check("final_drain_u16", 64'(exp_q16.size()), 64'd0);
    check("final_drain_u64", 64'(exp_q64.size()), 64'd0);
    check("final_drain_u8", 64'(exp_q8.size()), 64'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
